rr_arb_mux: RTL and testbench
=============================

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter T SHALL be: T, default logic, payload data type.
REQ-002 Parameter REQ_NUM SHALL be: REQ_NUM, default 4, number of requesters (>=2).
REQ-003 Port clk_i SHALL be: clk_i  input  1  single clock, all state on rising edge.
REQ-004 Port rst_i SHALL be: rst_i  input  1  reset, synchronous, active-high.
REQ-005 Port req_valid_i SHALL be: req_valid_i  input  REQ_NUM  per-requester valid.
REQ-006 Port req_data_i SHALL be: req_data_i  input  T [REQ_NUM-1:0] unpacked  per-requester payload.
REQ-007 Port req_ready_o SHALL be: req_ready_o  output  REQ_NUM  one-hot-or-zero accept, per requester.
REQ-008 Port out_valid_o SHALL be: out_valid_o  output  1  registered output holds a valid payload.
REQ-009 Port out_data_o SHALL be: out_data_o  output  T  registered selected payload.
REQ-010 Port out_src_oh_o SHALL be: out_src_oh_o  output  REQ_NUM  registered one-hot source of out_data_o.
REQ-011 Port out_ready_i SHALL be: out_ready_i  input  1  downstream accept.

Function
REQ-012 Block SHALL be a round-robin arbiter plus one-hot select plus one output register; request-to-output latency 1 cycle.
REQ-013 can_load = !out_valid_o || out_ready_i; grant SHALL be computed only when can_load=1, else req_ready_o=0.
REQ-014 Grant SHALL pick the first asserted req_valid_i at or above index ptr, wrapping REQ_NUM-1 -> 0; gnt is one-hot or zero.
REQ-015 req_ready_o SHALL equal gnt combinationally; requester handshake completes when req_valid_i[i] && req_ready_o[i].
REQ-016 On a grant, next cycle out_valid_o=1, out_data_o=req_data_i[granted], out_src_oh_o=gnt.
REQ-017 On a grant to index k, ptr SHALL become (k+1) mod REQ_NUM; no grant leaves ptr unchanged.
REQ-018 Output fire (out_valid_o && out_ready_i) with no new grant SHALL clear out_valid_o next cycle.
REQ-019 Output fire and new grant in same cycle SHALL reload the register: sustained throughput 1 transfer/cycle.
REQ-020 While out_valid_o && !out_ready_i, out_data_o and out_src_oh_o SHALL be stable and req_ready_o=0.
REQ-021 State SHALL be RR_IDLE (out_valid_o=0) or RR_HOLD (out_valid_o=1); IDLE->HOLD on grant, HOLD->IDLE on fire without grant, HOLD->HOLD otherwise.
REQ-022 Payload register SHALL load only on grant (no toggling when idle).
REQ-023 Under COMM_ASSERT, gnt SHALL be asserted $onehot0 and out_src_oh_o $onehot when out_valid_o.

Reset
REQ-024 rst_i=1 SHALL force next cycle: out_valid_o=0, out_src_oh_o=0, out_data_o=0, ptr=0, state RR_IDLE.
REQ-025 req_ready_o SHALL be 0 during any cycle rst_i=1; a held payload is dropped on reset mid-operation.

Structure
REQ-026 State enum rr_state_e {RR_IDLE, RR_HOLD} SHALL live in shared package comm_pkg.
REQ-027 ptr width SHALL be $clog2(REQ_NUM) as a local parameter; no other shared constants.
REQ-028 Payload selection SHALL instantiate existing onehot_mux (T, SEL_WIDTH=REQ_NUM) driven by gnt; round-robin logic stays in this module.

Verification (REQ_NUM=4, T=logic[7:0])
REQ-029 Reset, req_valid_i=4'b0000 -> out_valid_o=0, req_ready_o=0, ptr=0 for 10 cycles.
REQ-030 req_valid_i=4'b1111, data {0x33,0x22,0x11,0x00}, out_ready_i=1 -> outputs 0x00,0x11,0x22,0x33,0x00 on consecutive cycles; out_src_oh_o 0001,0010,0100,1000,0001.
REQ-031 ptr=3, req_valid_i=4'b0011 -> grant 0001 (wrap), then 0010, then 0001.
REQ-032 out_valid_o=1 data 0xA5, out_ready_i=0 for 5 cycles with req_valid_i=4'b0100 -> out_data_o stays 0xA5, req_ready_o=0; on out_ready_i=1 same cycle req_ready_o=0100, next cycle data = req_data_i[2].
REQ-033 rst_i asserted while out_valid_o=1 -> next cycle out_valid_o=0, out_src_oh_o=0, following grant with 4'b1111 selects index 0.
REQ-034 Random valid/ready 10k cycles -> no payload lost or duplicated, each continuously-valid requester served within 4 output transfers.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared communication types: arbiter output-stage state encoding.
package comm_pkg;

  typedef enum logic {
    RR_IDLE = 1'b0,
    RR_HOLD = 1'b1
  } rr_state_e;

endpackage

// File: rtl/onehot_mux.sv
// One-hot AND-OR selector: returns the payload whose select bit is set, zero if none.
module onehot_mux #(
  parameter type T         = logic,
  parameter int  SEL_WIDTH = 2
) (
  input  logic [SEL_WIDTH-1:0] sel_i,
  input  T                     data_i [SEL_WIDTH-1:0],
  output T                     data_o
);

  localparam int W = $bits(T);

  // OR together every payload whose select bit is set
  always_comb begin
    logic [W-1:0] acc;
    acc = '0;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      if (sel_i[i]) acc = acc | data_i[i];
    end
    data_o = T'(acc);
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin arbiter feeding a single registered output slot.
// A requester is granted only when the slot is empty or draining this cycle,
// so a stalled output blocks all requesters and holds its payload steady.
module rr_arb_mux
  import comm_pkg::*;
#(
  parameter type T       = logic,
  parameter int  REQ_NUM = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [REQ_NUM-1:0] req_valid_i,
  input  T                   req_data_i [REQ_NUM-1:0],
  output logic [REQ_NUM-1:0] req_ready_o,
  output logic               out_valid_o,
  output T                   out_data_o,
  output logic [REQ_NUM-1:0] out_src_oh_o,
  input  logic               out_ready_i
);

  localparam int PTR_W = $clog2(REQ_NUM);

  rr_state_e          state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [REQ_NUM-1:0] src_oh_q, src_oh_d;
  T                   data_q, data_d;
  logic [REQ_NUM-1:0] gnt;
  logic               can_load;
  T                   mux_data;

  assign out_valid_o  = (state_q == RR_HOLD);
  assign out_data_o   = data_q;
  assign out_src_oh_o = src_oh_q;
  assign can_load     = !out_valid_o || out_ready_i;
  assign req_ready_o  = gnt;

  onehot_mux #(
    .T         (T),
    .SEL_WIDTH (REQ_NUM)
  ) u_sel (
    .sel_i  (gnt),
    .data_i (req_data_i),
    .data_o (mux_data)
  );

  // Rotating priority search starting at ptr; reset suppresses any grant
  always_comb begin
    logic             found;
    int               idx;
    int               nxt;
    logic [PTR_W-1:0] idx_w;
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    nxt   = 0;
    idx_w = '0;
    if (can_load && !rst_i) begin
      for (int off = 0; off < REQ_NUM; off++) begin
        idx = int'(ptr_q) + off;
        if (idx >= REQ_NUM) idx = idx - REQ_NUM;
        idx_w = PTR_W'(idx);
        if (!found && req_valid_i[idx_w]) begin
          found      = 1'b1;
          gnt[idx_w] = 1'b1;
          nxt        = idx + 1;
          if (nxt == REQ_NUM) nxt = 0;
          ptr_d      = PTR_W'(nxt);
        end
      end
    end
  end

  // Output slot next state: load on grant, empty on fire without refill
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    src_oh_d = src_oh_q;
    if (|gnt) begin
      state_d  = RR_HOLD;
      data_d   = mux_data;
      src_oh_d = gnt;
    end else if (state_q == RR_HOLD && out_ready_i) begin
      state_d  = RR_IDLE;
    end
  end

  // State, pointer and payload registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RR_IDLE;
      ptr_q    <= '0;
      src_oh_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      src_oh_q <= src_oh_d;
      data_q   <= data_d;
    end
  end

`ifdef COMM_ASSERT
  // Grant and output source must never name more than one requester
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0(gnt));
      if (out_valid_o) assert ($onehot(src_oh_q));
    end
  end
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios plus randomized traffic against a reference model.
module tb_rr_arb_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  logic [7:0] req_data [3:0];
  logic [3:0] req_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] out_src;
  logic       out_ready;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic       m_vld;
  logic [7:0] m_data;
  logic [3:0] m_src;
  int         m_ptr;
  logic [7:0] sb[$];
  int         waits [4];
  logic [3:0] accepted;

  // random stimulus generator state
  logic       pending [4];
  int         seq [4];

  always #5 clk = ~clk;

  rr_arb_mux #(.T(logic [7:0]), .REQ_NUM(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_src_oh_o (out_src),
    .out_ready_i  (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // first requester with valid set, scanning from p upward with wrap
  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // one clock: check at negedge against the model, then advance model and clock
  task automatic cycle();
    int         k;
    int         dk;
    logic [3:0] eg;
    @(negedge clk);
    k  = (rst || !(!m_vld || out_ready)) ? -1 : pick(req_valid, m_ptr);
    eg = (k < 0) ? 4'b0000 : (4'b0001 << k);
    chk("req_ready", req_ready, eg);
    chk("out_valid", out_valid, m_vld);
    chk("out_data", out_data, m_data);
    chk("out_src", out_src, m_src);
    // scoreboard: output fire consumes the oldest accepted payload
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_extra_output", 1, 0);
      else chk("sb_data", out_data, sb.pop_front());
    end
    if (rst) sb.delete();
    // DUT-side handshake drives scoreboard and fairness tracking
    accepted = req_valid & req_ready;
    dk = -1;
    for (int i = 3; i >= 0; i--) if (accepted[i]) dk = i;
    for (int i = 0; i < 4; i++) if (!req_valid[i] || rst) waits[i] = 0;
    if (dk >= 0) begin
      chk("rr_fair", (waits[dk] <= 3), 1);
      for (int i = 0; i < 4; i++) if (i != dk && req_valid[i]) waits[i]++;
      waits[dk] = 0;
      sb.push_back(req_data[dk]);
    end
    // model update
    if (rst) begin
      m_vld = 1'b0; m_data = 8'h00; m_src = 4'b0000; m_ptr = 0;
    end else if (k >= 0) begin
      m_vld = 1'b1; m_data = req_data[k]; m_src = eg; m_ptr = (k + 1) % 4;
    end else if (m_vld && out_ready) begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_seq [5];
    logic [3:0] exp_src [5];
    rst = 1'b1; req_valid = 4'b0000; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_data[i] = 8'h00; waits[i] = 0; pending[i] = 1'b0; seq[i] = 0;
    end
    m_vld = 1'b0; m_data = 8'h00; m_src = 4'b0000; m_ptr = 0; accepted = 4'b0000;
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 1'b0;

    // idle after reset
    for (int c = 0; c < 10; c++) begin
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_ready", req_ready, 4'b0000);
      cycle();
    end

    // all requesting: rotation 0,1,2,3,0
    req_data[0] = 8'h00; req_data[1] = 8'h11; req_data[2] = 8'h22; req_data[3] = 8'h33;
    req_valid = 4'b1111;
    exp_seq = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    exp_src = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("rot_data", out_data, exp_seq[c]);
      chk("rot_src", out_src, exp_src[c]);
    end
    // grant 2 only -> pointer moves to 3
    req_valid = 4'b0100;
    cycle();
    req_valid = 4'b0000;
    cycle();
    chk("drain_valid", out_valid, 1'b0);

    // wrap from pointer 3
    req_valid = 4'b0011;
    #1 chk("wrap_gnt0", req_ready, 4'b0001);
    cycle();
    #1 chk("wrap_gnt1", req_ready, 4'b0010);
    cycle();
    #1 chk("wrap_gnt2", req_ready, 4'b0001);
    cycle();
    req_valid = 4'b0000;
    cycle();

    // backpressure holds payload and blocks grants
    req_data[2] = 8'hA5; req_valid = 4'b0100; out_ready = 1'b1;
    cycle();
    chk("bp_load", out_data, 8'hA5);
    req_data[2] = 8'h5A; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp_ready", req_ready, 4'b0000);
      cycle();
      chk("bp_hold", out_data, 8'hA5);
    end
    out_ready = 1'b1;
    #1 chk("bp_release", req_ready, 4'b0100);
    cycle();
    chk("bp_next", out_data, 8'h5A);

    // reset while holding drops the payload
    out_ready = 1'b0; req_valid = 4'b0000;
    rst = 1'b1;
    #1 chk("rst_ready", req_ready, 4'b0000);
    cycle();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_src", out_src, 4'b0000);
    chk("rst_data", out_data, 8'h00);
    rst = 1'b0; req_valid = 4'b1111; out_ready = 1'b1;
    #1 chk("rst_first", req_ready, 4'b0001);
    cycle();
    req_valid = 4'b0000;
    cycle();

    // randomized traffic
    for (int i = 0; i < 4; i++) pending[i] = 1'b0;
    accepted = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (accepted[i]) begin
          pending[i] = 1'b0;
          seq[i]     = seq[i] + 1;
        end
        if (!pending[i] && ($urandom_range(0, 2) == 0)) begin
          pending[i]  = 1'b1;
          req_data[i] = {i[1:0], seq[i][5:0]};
        end
        req_valid[i] = pending[i];
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // drain
    req_valid = 4'b0000; out_ready = 1'b1;
    cycle(); cycle();
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
